io_port_arbiter: RTL and testbench

Sequencer and round-robin arbiter that shares one bank of `digital_io` pin cells between several requesters. It accepts single-shot read or write transactions, drives the bank's `en`/`direction`/`data_in` controls for exactly one access cycle, and returns the pin values sampled in that cycle. It sits between peripheral engines and the `WIDTH` `digital_io` instances that make up a port.

---
 rtl/io_port_arbiter.sv | 126 ++++++++++++
 tb/tb_io_port_arbiter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/io_port_arbiter.sv
// Round-robin sequencer sharing one bank of digital_io pin cells between NREQ requesters.
// Optional direction-change turnaround cycle: define IO_ARB_TURNAROUND_EN.
module io_port_arbiter #(
  parameter int NREQ  = 2,
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ-1:0]       req_dir,
  input  logic [NREQ*WIDTH-1:0] req_mask,
  input  logic [NREQ*WIDTH-1:0] req_wdata,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       done,
  output logic [WIDTH-1:0]      rdata,
  output logic [WIDTH-1:0]      io_en,
  output logic [WIDTH-1:0]      io_dir,
  output logic [WIDTH-1:0]      io_wdata,
  input  logic [WIDTH-1:0]      io_rdata
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [2:0] {IDLE, TURN, ACCESS, CAPTURE, DONE} state_t;

  state_t             state;
  logic [IDX_W-1:0]   last, cur_idx, sel_idx, cand;
  logic               sel_found, sel_dir, cur_dir, turn_needed;
  logic [WIDTH-1:0]   sel_mask, sel_wdata, cur_mask, cur_wdata;

`ifdef IO_ARB_TURNAROUND_EN
  logic prev_dir;
`endif

  // Rotating priority: the search starts just after the last winner.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    sel_idx   = last;
    sel_found = 1'b0;
    cand      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IDX_W'((int'(last) + k) % NREQ);
      if (!sel_found && req[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
    sel_dir   = req_dir[sel_idx];
    sel_mask  = req_mask[int'(sel_idx)*WIDTH +: WIDTH];
    sel_wdata = req_wdata[int'(sel_idx)*WIDTH +: WIDTH];
`ifdef IO_ARB_TURNAROUND_EN
    turn_needed = (sel_dir != prev_dir);
`else
    turn_needed = 1'b0;
`endif
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      gnt       <= '0;
      done      <= '0;
      rdata     <= '0;
      io_en     <= '0;
      io_dir    <= '0;
      io_wdata  <= '0;
      last      <= IDX_W'(NREQ - 1);
      cur_idx   <= '0;
      cur_dir   <= 1'b0;
      cur_mask  <= '0;
      cur_wdata <= '0;
`ifdef IO_ARB_TURNAROUND_EN
      prev_dir  <= 1'b0;
`endif
    end else begin
      gnt  <= '0;
      done <= '0;
      case (state)
        IDLE: begin
          if (sel_found) begin
            cur_idx   <= sel_idx;
            cur_dir   <= sel_dir;
            cur_mask  <= sel_mask;
            cur_wdata <= sel_wdata;
            gnt       <= NREQ'(1) << sel_idx;
            if (turn_needed) begin
              state <= TURN;
              io_en <= '0;
            end else begin
              state    <= ACCESS;
              io_en    <= sel_mask;
              io_dir   <= sel_dir ? sel_mask : '0;
              io_wdata <= sel_wdata & sel_mask;
            end
          end
        end
        TURN: begin
          state    <= ACCESS;
          io_en    <= cur_mask;
          io_dir   <= cur_dir ? cur_mask : '0;
          io_wdata <= cur_wdata & cur_mask;
        end
        ACCESS: begin
          // Pins were sampled/loaded on this edge; drop enables, keep dir/data steady.
          state <= CAPTURE;
          io_en <= '0;
        end
        CAPTURE: begin
          state <= DONE;
          rdata <= io_rdata & cur_mask;
          done  <= NREQ'(1) << cur_idx;
        end
        DONE: begin
          state    <= IDLE;
          last     <= cur_idx;
`ifdef IO_ARB_TURNAROUND_EN
          prev_dir <= cur_dir;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_io_port_arbiter.sv
// Directed bench for io_port_arbiter: scoreboarded completions plus per-phase pin-control checks.
module tb_io_port_arbiter;
  localparam int NREQ  = 2;
  localparam int WIDTH = 8;
`ifdef IO_ARB_TURNAROUND_EN
  localparam bit TURN_EN = 1'b1;
`else
  localparam bit TURN_EN = 1'b0;
`endif

  typedef struct {
    int         idx;
    logic [7:0] rdata;
  } exp_t;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NREQ-1:0]       req;
  logic [NREQ-1:0]       req_dir;
  logic [NREQ*WIDTH-1:0] req_mask;
  logic [NREQ*WIDTH-1:0] req_wdata;
  logic [NREQ-1:0]       gnt, done;
  logic [WIDTH-1:0]      rdata, io_en, io_dir, io_wdata, io_rdata;

  // Pin bank model: driven bits hold the last written value, others follow ext_pins.
  logic [WIDTH-1:0] ext_pins;
  logic [WIDTH-1:0] out_reg = '0;
  logic [WIDTH-1:0] out_act = '0;
  assign io_rdata = (out_act & out_reg) | (~out_act & ext_pins);

  always @(posedge clk)
    for (int b = 0; b < WIDTH; b++)
      if (io_en[b] && io_dir[b]) begin
        out_reg[b] <= io_wdata[b];
        out_act[b] <= 1'b1;
      end

  int   compared   = 0;
  int   mismatched = 0;
  exp_t sb[$];
  logic prev_dir_m = 1'b0;

  io_port_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_dir(req_dir), .req_mask(req_mask),
    .req_wdata(req_wdata), .gnt(gnt), .done(done), .rdata(rdata), .io_en(io_en),
    .io_dir(io_dir), .io_wdata(io_wdata), .io_rdata(io_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Completion monitor: one-hot grant and scoreboard pop on every done pulse.
  always @(negedge clk) begin
    if (gnt != '0) check("gnt_onehot", 32'($onehot(gnt)), 32'd1);
    if (done != '0) begin
      check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        check("sb_done_idx", 32'(done), 32'(1 << e.idx));
        check("sb_rdata", 32'(rdata), 32'(e.rdata));
      end
    end
  end

  task automatic wait_gnt(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (gnt == '0 && lat < 10);
  endtask

  task automatic drive(input int i, input logic dir, input logic [7:0] mask, input logic [7:0] wdata);
    req_dir[i]            = dir;
    req_mask[i*WIDTH +: WIDTH]  = mask;
    req_wdata[i*WIDTH +: WIDTH] = wdata;
    req[i]                = 1'b1;
  endtask

  // One uncontended transaction from IDLE with phase-by-phase pin-control checks.
  task automatic run(input int i, input logic dir, input logic [7:0] mask,
                     input logic [7:0] wdata, input logic [7:0] exp);
    int   lat;
    logic turn;
    @(negedge clk);
    check("idle_gnt", 32'(gnt), 32'd0);
    drive(i, dir, mask, wdata);
    sb.push_back('{i, exp});
    turn = TURN_EN && (dir != prev_dir_m);
    wait_gnt(lat);
    check("gnt", 32'(gnt), 32'(1 << i));
    check("gnt_lat", 32'(lat), 32'd1);
    req[i] = 1'b0;
    if (turn) begin
      check("turn_en", 32'(io_en), 32'd0);
      @(negedge clk);
      check("acc_gnt_low", 32'(gnt), 32'd0);
    end
    check("acc_en", 32'(io_en), 32'(mask));
    check("acc_dir", 32'(io_dir), 32'(dir ? mask : 8'h00));
    check("acc_wdata", 32'(io_wdata), 32'(wdata & mask));
    @(negedge clk);
    check("cap_en", 32'(io_en), 32'd0);
    check("cap_dir", 32'(io_dir), 32'(dir ? mask : 8'h00));
    check("cap_done_low", 32'(done), 32'd0);
    @(negedge clk);
    check("done", 32'(done), 32'(1 << i));
    check("rdata", 32'(rdata), 32'(exp));
    prev_dir_m = dir;
  endtask

  initial begin
    int lat;
    rst_n = 1'b0; req = '0; req_dir = '0; req_mask = '0; req_wdata = '0; ext_pins = 8'h5A;

    // Reset: two cycles low, every output cleared.
    repeat (2) @(negedge clk);
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_rdata", 32'(rdata), 32'd0);
    check("rst_io_en", 32'(io_en), 32'd0);
    check("rst_io_dir", 32'(io_dir), 32'd0);
    check("rst_io_wdata", 32'(io_wdata), 32'd0);
    rst_n = 1'b1;

    // First request from requester 1 alone; read of undriven pins.
    run(1, 1'b0, 8'hFF, 8'h00, 8'h5A);

    // Read with partial mask.
    ext_pins = 8'hA5;
    run(0, 1'b0, 8'h0F, 8'h77, 8'h05);

    // Write, readback in the same transaction, then read it back.
    run(1, 1'b1, 8'hFF, 8'h3C, 8'h3C);
    ext_pins = 8'h00;
    run(0, 1'b0, 8'hFF, 8'h00, 8'h3C);

    // All-zero mask: nothing enabled, rdata 0.
    run(1, 1'b1, 8'h00, 8'hFF, 8'h00);

    // Contention: both held, strict rotation starting at requester 0.
    @(negedge clk);
    drive(0, 1'b0, 8'hFF, 8'h00);
    drive(1, 1'b0, 8'hF0, 8'h00);
    for (int t = 0; t < 4; t++) sb.push_back('{t % 2, (t % 2 == 0) ? 8'h3C : 8'h30});
    for (int t = 0; t < 4; t++) begin
      wait_gnt(lat);
      check("cont_gnt", 32'(gnt), 32'(1 << (t % 2)));
      if (t == 3) req = '0;
    end
    prev_dir_m = 1'b0;
    lat = 0;
    do begin @(negedge clk); lat++; end while (done == '0 && lat < 10);
    check("cont_last_done", 32'(done), 32'b10);

    // Reset mid-transaction during CAPTURE: no done, restart from IDLE.
    @(negedge clk);
    drive(0, 1'b0, 8'hFF, 8'h00);
    wait_gnt(lat);
    check("mid_gnt", 32'(gnt), 32'b01);
    @(negedge clk);
    check("mid_cap_en", 32'(io_en), 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_rdata", 32'(rdata), 32'd0);
    check("mid_rst_io_dir", 32'(io_dir), 32'd0);
    prev_dir_m = 1'b0;
    sb.push_back('{0, 8'h3C});
    rst_n = 1'b1;
    wait_gnt(lat);
    check("restart_gnt", 32'(gnt), 32'b01);
    check("restart_lat", 32'(lat), 32'd1);
    req = '0;
    lat = 0;
    do begin @(negedge clk); lat++; end while (done == '0 && lat < 10);
    check("restart_done_lat", 32'(lat), 32'd2);

    repeat (3) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
